// File: rtl/plab4_net_ring_link_sep.sv
// Ring link with one independent FIFO per security domain.
// Illegal-domain messages are accepted and dropped, with a saturating count.
module plab4_net_ring_link_sep #(
  parameter int p_msg_cnbits  = 38,
  parameter int p_msg_dnbits  = 32,
  parameter int p_num_domains = 2,
  parameter int p_depth       = 4,
  localparam int c_dom_nbits  =
    (p_num_domains > 1) ? $clog2(p_num_domains) : 1,
  localparam int c_cnt_nbits  = $clog2(p_depth) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_val,
  output logic in_rdy,
  input  logic [c_dom_nbits-1:0] in_domain,
  input  logic [p_msg_cnbits-1:0] in_msg_control,
  input  logic [p_msg_dnbits-1:0] in_msg_data,
  output logic [p_num_domains-1:0] out_val,
  input  logic [p_num_domains-1:0] out_rdy,
  output logic [p_num_domains*p_msg_cnbits-1:0] out_msg_control,
  output logic [p_num_domains*p_msg_dnbits-1:0] out_msg_data,
  output logic [p_num_domains*c_cnt_nbits-1:0] num_free,
  output logic [7:0] drop_count
);

  localparam int c_ptr_nbits = $clog2(p_depth);
  localparam int c_w = p_msg_cnbits + p_msg_dnbits;
  localparam logic [c_cnt_nbits-1:0] c_depth =
    c_cnt_nbits'(p_depth);

  logic [c_cnt_nbits-1:0] cnt_q [p_num_domains];
  logic [c_cnt_nbits-1:0] cnt_d [p_num_domains];
  logic [c_ptr_nbits-1:0] rd_q  [p_num_domains];
  logic [c_ptr_nbits-1:0] rd_d  [p_num_domains];
  logic [c_ptr_nbits-1:0] wr_q  [p_num_domains];
  logic [c_ptr_nbits-1:0] wr_d  [p_num_domains];
  logic [c_w-1:0] mem_q [p_num_domains][p_depth];
  logic [c_w-1:0] head  [p_num_domains];
  logic [7:0] drop_q, drop_d;
  logic [p_num_domains-1:0] enq, deq;
  logic legal, in_full;

  // Full check via loop so an illegal index never reads the count array
  always_comb begin
    legal   = int'(in_domain) < p_num_domains;
    in_full = 1'b0;
    for (int k = 0; k < p_num_domains; k++)
      if (int'(in_domain) == k)
        in_full = (cnt_q[k] == c_depth);
    in_rdy = !in_full;
  end

  always_comb begin
    drop_d = drop_q;
    for (int k = 0; k < p_num_domains; k++) begin
      enq[k] = in_val && in_rdy && (int'(in_domain) == k);
      deq[k] = (cnt_q[k] != '0) && out_rdy[k];
      cnt_d[k] = cnt_q[k] + c_cnt_nbits'(enq[k])
                 - c_cnt_nbits'(deq[k]);
      wr_d[k] = wr_q[k] + c_ptr_nbits'(enq[k]);
      rd_d[k] = rd_q[k] + c_ptr_nbits'(deq[k]);
    end
    if (in_val && !legal && drop_q != 8'hff)
      drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
      for (int k = 0; k < p_num_domains; k++) begin
        cnt_q[k] <= '0;
        rd_q[k]  <= '0;
        wr_q[k]  <= '0;
      end
    end else begin
      drop_q <= drop_d;
      for (int k = 0; k < p_num_domains; k++) begin
        cnt_q[k] <= cnt_d[k];
        rd_q[k]  <= rd_d[k];
        wr_q[k]  <= wr_d[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < p_num_domains; k++)
      if (enq[k])
        mem_q[k][wr_q[k]] <= {in_msg_control, in_msg_data};
  end

  // Empty slices are forced to zero so stale storage never leaks out
  always_comb begin
    for (int k = 0; k < p_num_domains; k++) begin
      out_val[k] = (cnt_q[k] != '0);
      head[k] = mem_q[k][rd_q[k]];
      out_msg_control[k*p_msg_cnbits +: p_msg_cnbits] =
        out_val[k] ? head[k][c_w-1 -: p_msg_cnbits] : '0;
      out_msg_data[k*p_msg_dnbits +: p_msg_dnbits] =
        out_val[k] ? head[k][p_msg_dnbits-1:0] : '0;
      num_free[k*c_cnt_nbits +: c_cnt_nbits] = c_depth - cnt_q[k];
    end
    drop_count = drop_q;
  end

endmodule
